// File: rtl/mul_datapath_controller_if.sv
// Operand/result bundle for the shift-free repeated-add multiplier.
// The master drives the request and operands; the slave returns the datapath view.
interface mul_datapath_controller_if;
  logic        start;
  logic [15:0] data_in;
  logic [15:0] product;
  logic [15:0] a_out;
  logic [15:0] b_out;
  logic        eqz;
  logic        done;

  modport master (
    output start,
    output data_in,
    input  product,
    input  a_out,
    input  b_out,
    input  eqz,
    input  done
  );

  modport slave (
    input  start,
    input  data_in,
    output product,
    output a_out,
    output b_out,
    output eqz,
    output done
  );
endinterface

// File: rtl/mul_datapath_controller.sv
// Repeated-addition multiplier: P accumulates A while B counts down to zero.
// Controller and datapath share one file; strobes decode from state and eqz.
module mul_datapath_controller (
  input  logic                       clk,
  input  logic                       rst_n,
  mul_datapath_controller_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOADA,
    LOADB,
    MUL,
    DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [15:0] r_p;
  logic        w_eqz;
  logic        w_ld_a;
  logic        w_ld_b;
  logic        w_ld_p;
  logic        w_clr_p;
  logic        w_dec_b;

  assign w_eqz = (r_b == 16'd0);

  always_comb begin
    w_next  = r_state;
    w_ld_a  = 1'b0;
    w_ld_b  = 1'b0;
    w_ld_p  = 1'b0;
    w_clr_p = 1'b0;
    w_dec_b = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.start) w_next = LOADA;
      end
      LOADA: begin
        w_ld_a = 1'b1;
        w_next = LOADB;
      end
      LOADB: begin
        w_ld_b  = 1'b1;
        w_clr_p = 1'b1;
        w_next  = MUL;
      end
      MUL: begin
        // Counter at zero: leave without touching P or B
        if (w_eqz) begin
          w_next = DONE;
        end else begin
          w_ld_p  = 1'b1;
          w_dec_b = 1'b1;
        end
      end
      DONE: begin
        if (!bus.start) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= 16'd0;
      r_b     <= 16'd0;
      r_p     <= 16'd0;
    end else begin
      r_state <= w_next;
      if (w_ld_a) r_a <= bus.data_in;
      if (w_ld_b) begin
        r_b <= bus.data_in;
      end else if (w_dec_b) begin
        r_b <= r_b - 16'd1;
      end
      if (w_clr_p) begin
        r_p <= 16'd0;
      end else if (w_ld_p) begin
        r_p <= r_p + r_a;
      end
    end
  end

  assign bus.product = r_p;
  assign bus.a_out   = r_a;
  assign bus.b_out   = r_b;
  assign bus.eqz     = w_eqz;
  assign bus.done    = (r_state == DONE);

endmodule

// File: tb/tb_mul_datapath_controller.sv
// Directed bench for mul_datapath_controller with an expected-result queue.
// Checks reset, per-step accumulation, latency, wrap, mid-run reset and start hold.
module tb_mul_datapath_controller;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] p;
    int          lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  exp_t sb[$];

  mul_datapath_controller_if bus ();

  mul_datapath_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one multiplication from IDLE; leaves start high when hold=1.
  task automatic run(input logic [15:0] a,
                     input logic [15:0] b,
                     input bit hold);
    exp_t        e;
    int          n;
    logic [31:0] stepv;
    e.a   = a;
    e.b   = b;
    e.p   = 16'(32'(a) * 32'(b));
    e.lat = 3 + int'(b);
    sb.push_back(e);
    bus.start = 1'b1;
    tick();
    if (!hold) bus.start = 1'b0;
    bus.data_in = a;
    tick();
    bus.data_in = b;
    tick();
    n = 2;
    while (!bus.done && n < e.lat + 20) begin
      stepv = (32'(a) * (32'(b) - 32'(bus.b_out))) & 32'h0000_FFFF;
      check("step_product", 32'(bus.product), stepv);
      bus.data_in = 16'($urandom);
      tick();
      n++;
    end
    e = sb.pop_front();
    check("latency", n, e.lat);
    check("product", 32'(bus.product), 32'(e.p));
    check("a_out", 32'(bus.a_out), 32'(e.a));
    check("b_out", 32'(bus.b_out), 32'd0);
    check("done", 32'(bus.done), 32'd1);
    check("eqz", 32'(bus.eqz), 32'd1);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.data_in = 16'hDEAD;
    tick();
    tick();
    check("rst_product", 32'(bus.product), 32'd0);
    check("rst_a", 32'(bus.a_out), 32'd0);
    check("rst_b", 32'(bus.b_out), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_eqz", 32'(bus.eqz), 32'd1);
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_done", 32'(bus.done), 32'd0);
    check("idle_product", 32'(bus.product), 32'd0);

    run(16'd10, 16'd5, 1'b0);
    tick();
    check("back_idle", 32'(bus.done), 32'd0);
    run(16'd7, 16'd0, 1'b0);
    tick();
    run(16'd0, 16'd4, 1'b0);
    tick();
    run(16'd300, 16'd300, 1'b0);
    tick();

    // Reset in the middle of a 10x5 run after two additions
    bus.start = 1'b1;
    tick();
    bus.start   = 1'b0;
    bus.data_in = 16'd10;
    tick();
    bus.data_in = 16'd5;
    tick();
    tick();
    tick();
    check("mid_product", 32'(bus.product), 32'd20);
    check("mid_b", 32'(bus.b_out), 32'd3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mrst_product", 32'(bus.product), 32'd0);
    check("mrst_a", 32'(bus.a_out), 32'd0);
    check("mrst_b", 32'(bus.b_out), 32'd0);
    check("mrst_done", 32'(bus.done), 32'd0);
    check("mrst_eqz", 32'(bus.eqz), 32'd1);
    tick();
    tick();
    tick();
    check("mrst_wait_done", 32'(bus.done), 32'd0);
    check("mrst_wait_prod", 32'(bus.product), 32'd0);
    run(16'd3, 16'd4, 1'b0);
    tick();

    // Start held through the whole run and into DONE
    run(16'd20, 16'd3, 1'b1);
    repeat (3) begin
      tick();
      check("hold_done", 32'(bus.done), 32'd1);
      check("hold_product", 32'(bus.product), 32'd60);
    end
    bus.start = 1'b0;
    tick();
    check("release_done", 32'(bus.done), 32'd0);
    check("release_product", 32'(bus.product), 32'd60);
    run(16'd6, 16'd6, 1'b0);
    tick();
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
